player_motion_ctrl: RTL and testbench



---
 rtl/vga_game_pkg.sv | 15 +
 rtl/pulse_stepper.sv | 31 +++
 rtl/player_motion_ctrl.sv | 122 ++++++++++++
 tb/tb_player_motion_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
// vga_game_pkg: shared geometry, physics defaults and motion FSM states for the VGA game.
package vga_game_pkg;
  localparam int kPlayerW    = 32;
  localparam int kPlayerH    = 32;
  localparam int kRangeX     = 640 - kPlayerW;
  localparam int kGrassTop   = 400;
  localparam int kSpeedX     = 9;
  localparam int kInitVelY   = 21;
  localparam int kBounceBase = 19;
  localparam int kHeartInit  = 9;
  localparam int kHeartMax   = 200;
  localparam int kHeartMin   = 20;
  localparam int kHeartStep  = 10;
  typedef enum logic [2:0] {IDLE, STEP_X, STEP_Y, STEP_HEART, COMMIT} state_e;
endpackage

// File: rtl/pulse_stepper.sv
// pulse_stepper: bounded up/down counter that reverses (holding its value for one step) at its limits.
module pulse_stepper #(
  parameter int W    = 11,
  parameter int INIT = 9,
  parameter int MAX  = 200,
  parameter int MIN  = 20,
  parameter int STEP = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;
  logic up_q, up_d, hold;
  always_comb begin
    hold    = up_q ? (value_q >= W'(MAX)) : (value_q < W'(MIN));
    up_d    = (en && hold) ? ~up_q : up_q;
    value_d = (en && !hold) ? (up_q ? value_q + W'(STEP) : value_q - W'(STEP)) : value_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= W'(INIT);
      up_q    <= 1'b1;
    end else begin
      value_q <= value_d;
      up_q    <= up_d;
    end
  end
  assign value = value_q;
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame X/Y/heart update sequence computed into shadows and committed atomically.
module player_motion_ctrl
  import vga_game_pkg::*;
#(
  parameter int RANGE_X     = kRangeX,
  parameter int SPEED_X     = kSpeedX,
  parameter int INIT_VEL_Y  = kInitVelY,
  parameter int BOUNCE_BASE = kBounceBase,
  parameter int HEART_INIT  = kHeartInit,
  parameter int HEART_MAX   = kHeartMax,
  parameter int HEART_MIN   = kHeartMin,
  parameter int HEART_STEP  = kHeartStep
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_end,
  input  logic        pause,
  output logic [9:0]  px,
  output logic [9:0]  py,
  output logic [10:0] heart_thresh,
  output logic        busy,
  output logic        bounce,
  output logic        overrun
);
  state_e state_q, state_d;
  logic [11:0] pxm_q, pxm_d, pxm_s_q, pxm_s_d;
  logic signed [11:0] pym_q, pym_d, pym_s_q, pym_s_d;
  logic signed [7:0] yd_q, yd_d, yd_s_q, yd_s_d;
  logic [10:0] heart_q, heart_d, heart_s;
  logic dx_q, dx_d, dx_s_q, dx_s_d, bflag_q, bflag_d;
  logic bounce_q, bounce_d, overrun_q, overrun_d;
  logic dx_new, hit;
  logic [8:0] neg_yd;
  pulse_stepper #(
    .W(11), .INIT(HEART_INIT), .MAX(HEART_MAX), .MIN(HEART_MIN), .STEP(HEART_STEP)
  ) u_heart (
    .clk(clk), .reset(reset), .en(state_q == STEP_HEART), .value(heart_s)
  );
  always_comb begin
    state_d   = state_q;
    pxm_d     = pxm_q;
    pym_d     = pym_q;
    yd_d      = yd_q;
    dx_d      = dx_q;
    heart_d   = heart_q;
    pxm_s_d   = pxm_s_q;
    pym_s_d   = pym_s_q;
    yd_s_d    = yd_s_q;
    dx_s_d    = dx_s_q;
    bflag_d   = bflag_q;
    bounce_d  = 1'b0;
    overrun_d = frame_end && (state_q != IDLE);
    dx_new    = (px >= 10'(RANGE_X)) ? 1'b0 : (px == 10'd0) ? 1'b1 : dx_q;
    neg_yd    = 9'd0 - {yd_q[7], yd_q};
    // Landing: falling and the remaining height fits within one step of the current velocity
    hit       = yd_q[7] && (pym_q[11:8] == 4'd0) && ({1'b0, pym_q[7:0]} <= neg_yd);
    case (state_q)
      IDLE: state_d = (frame_end && !pause) ? STEP_X : IDLE;
      STEP_X: begin
        dx_s_d  = dx_new;
        pxm_s_d = dx_new ? pxm_q + 12'(SPEED_X)
                         : (pxm_q < 12'(SPEED_X) ? 12'd0 : pxm_q - 12'(SPEED_X));
        state_d = STEP_Y;
      end
      STEP_Y: begin
        pym_s_d = hit ? 12'sd0 : pym_q + {{4{yd_q[7]}}, yd_q};
        yd_s_d  = hit ? 8'(BOUNCE_BASE) + 8'(px[1:0]) : yd_q - 8'sd1;
        bflag_d = hit;
        state_d = STEP_HEART;
      end
      STEP_HEART: state_d = COMMIT;
      COMMIT: begin
        pxm_d    = pxm_s_q;
        pym_d    = pym_s_q;
        yd_d     = yd_s_q;
        dx_d     = dx_s_q;
        heart_d  = heart_s;
        bounce_d = bflag_q;
        bflag_d  = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pxm_q     <= '0;
      pym_q     <= '0;
      yd_q      <= 8'(INIT_VEL_Y);
      dx_q      <= 1'b1;
      heart_q   <= 11'(HEART_INIT);
      pxm_s_q   <= '0;
      pym_s_q   <= '0;
      yd_s_q    <= 8'(INIT_VEL_Y);
      dx_s_q    <= 1'b1;
      bflag_q   <= 1'b0;
      bounce_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pxm_q     <= pxm_d;
      pym_q     <= pym_d;
      yd_q      <= yd_d;
      dx_q      <= dx_d;
      heart_q   <= heart_d;
      pxm_s_q   <= pxm_s_d;
      pym_s_q   <= pym_s_d;
      yd_s_q    <= yd_s_d;
      dx_s_q    <= dx_s_d;
      bflag_q   <= bflag_d;
      bounce_q  <= bounce_d;
      overrun_q <= overrun_d;
    end
  end
  assign px           = pxm_q[11:2];
  assign py           = pym_q[9:0];
  assign heart_thresh = heart_q;
  assign busy         = state_q != IDLE;
  assign bounce       = bounce_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed checks of reset, motion, bounce, heart sweep, pause, overrun and mid-sequence reset.
module tb_player_motion_ctrl;
  logic clk = 1'b0;
  logic reset, frame_end, pause;
  logic [9:0] px, py;
  logic [10:0] heart_thresh;
  logic busy, bounce, overrun;
  int compared = 0;
  int mism = 0;
  int bounce_cnt = 0;
  logic busy_seen, ovr_seen;

  player_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .pause(pause),
    .px(px), .py(py), .heart_thresh(heart_thresh),
    .busy(busy), .bounce(bounce), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    compared++;
    assert (act === want) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, want);
    end
  endtask

  task automatic pulse_fe();
    @(negedge clk) frame_end = 1'b1;
    @(negedge clk) frame_end = 1'b0;
  endtask

  task automatic frame();
    pulse_fe();
    repeat (4) @(negedge clk);
    if (bounce) bounce_cnt++;
  endtask

  initial begin
    reset = 1'b1; frame_end = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_px", 32'(px), 0);
    check("rst_py", 32'(py), 0);
    check("rst_heart", 32'(heart_thresh), 9);
    check("rst_busy", 32'(busy), 0);
    check("rst_bounce", 32'(bounce), 0);
    check("rst_overrun", 32'(overrun), 0);
    // frame 1 with cycle-level busy/latency checks
    pulse_fe();
    check("f1_busy_n1", 32'(busy), 1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("f1_busy_n2_4", 32'(busy), 1);
      check("f1_px_held", 32'(px), 0);
    end
    @(negedge clk);
    check("f1_px", 32'(px), 2);
    check("f1_py", 32'(py), 21);
    check("f1_heart", 32'(heart_thresh), 19);
    check("f1_busy_n5", 32'(busy), 0);
    check("f1_bounce", 32'(bounce), 0);
    repeat (19) frame();
    check("f20_heart", 32'(heart_thresh), 209);
    check("f20_px", 32'(px), 45);
    check("f20_py", 32'(py), 230);
    frame();
    check("f21_heart_hold", 32'(heart_thresh), 209);
    frame();
    check("f22_heart", 32'(heart_thresh), 199);
    repeat (18) frame();
    check("f40_heart", 32'(heart_thresh), 19);
    frame();
    check("f41_heart_hold", 32'(heart_thresh), 19);
    frame();
    check("f42_heart", 32'(heart_thresh), 29);
    check("f42_py", 32'(py), 21);
    check("f42_px", 32'(px), 94);
    check("f1_42_no_bounce", 32'(bounce_cnt), 0);
    frame();
    check("f43_bounce", 32'(bounce), 1);
    check("f43_py", 32'(py), 0);
    check("f43_heart", 32'(heart_thresh), 39);
    @(negedge clk);
    check("f43_bounce_1cyc", 32'(bounce), 0);
    frame();
    check("f44_py", 32'(py), 21);
    check("f44_bounce", 32'(bounce), 0);
    // paused frame_ends are ignored entirely
    pause = 1'b1;
    busy_seen = 1'b0; ovr_seen = 1'b0;
    repeat (3) begin
      pulse_fe();
      repeat (5) begin
        busy_seen |= busy; ovr_seen |= overrun;
        @(negedge clk);
      end
    end
    pause = 1'b0;
    check("pause_busy", 32'(busy_seen), 0);
    check("pause_overrun", 32'(ovr_seen), 0);
    check("pause_px", 32'(px), 99);
    check("pause_py", 32'(py), 21);
    check("pause_heart", 32'(heart_thresh), 49);
    // frame 45 with a second frame_end two cycles in
    pulse_fe();
    @(negedge clk) frame_end = 1'b1;
    @(negedge clk) frame_end = 1'b0;
    check("ovr_pulse", 32'(overrun), 1);
    check("ovr_busy_n3", 32'(busy), 1);
    @(negedge clk);
    check("ovr_pulse_end", 32'(overrun), 0);
    check("ovr_busy_n4", 32'(busy), 1);
    @(negedge clk);
    check("ovr_busy_n5", 32'(busy), 0);
    check("f45_px", 32'(px), 101);
    check("f45_heart", 32'(heart_thresh), 59);
    @(negedge clk);
    check("ovr_not_counted", 32'(busy), 0);
    repeat (226) frame();
    check("f271_px", 32'(px), 609);
    frame();
    check("f272_px_rev", 32'(px), 607);
    repeat (270) frame();
    check("f542_px_left_edge", 32'(px), 0);
    frame();
    check("f543_px_right", 32'(px), 2);
    // reset while the sequence is in STEP_Y
    pulse_fe();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rsty_busy", 32'(busy), 0);
    check("rsty_px", 32'(px), 0);
    check("rsty_py", 32'(py), 0);
    check("rsty_heart", 32'(heart_thresh), 9);
    busy_seen = 1'b0; ovr_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      busy_seen |= busy; ovr_seen |= bounce;
    end
    check("rsty_idle", 32'(busy_seen), 0);
    check("rsty_no_bounce", 32'(ovr_seen), 0);
    check("rsty_px_hold", 32'(px), 0);
    frame();
    check("rsty_f1_px", 32'(px), 2);
    check("rsty_f1_py", 32'(py), 21);
    check("rsty_f1_heart", 32'(heart_thresh), 19);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
